pe_tile_config_regs: RTL and testbench

Parametrised configuration register bank for a PE tile. Matches `config_addr` against `tile_id`, stages writes into shadow registers, and on a commit command copies dirty shadows into the active registers that drive the PE, connect boxes and switch box. Supports readback and a valid/ready handshake. It replaces the per-target fixed address matchers inside the tile with one bank.

---
 rtl/pe_tile_config_regs_pkg.sv | 18 +
 rtl/pe_tile_config_regs_if.sv | 24 ++
 rtl/pe_tile_config_regs_decode.sv | 37 +++
 rtl/pe_tile_config_regs.sv | 164 ++++++++++++++++
 tb/tb_pe_tile_config_regs.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pe_tile_config_regs_pkg.sv
// Shared definitions for the PE tile configuration register bank:
// special reg_id codes and the commit FSM state encoding.
package pe_tile_cfg_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REGID_W = 16;

  localparam logic [REGID_W-1:0] REG_ID_COMMIT = 16'hFFFF;
  localparam logic [REGID_W-1:0] REG_ID_ABORT  = 16'hFFFE;
  localparam logic [REGID_W-1:0] REG_ID_STATUS = 16'hFFFD;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/pe_tile_config_regs_if.sv
// Configuration command bus: valid/ready command channel plus registered
// readback. master = config source, slave = register bank.
interface pe_tile_config_regs_if;
  import pe_tile_cfg_pkg::*;

  logic              config_valid;
  logic              config_ready;
  logic              config_we;
  logic [ADDR_W-1:0] config_addr;
  logic [DATA_W-1:0] config_data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;

  modport master (
    output config_valid, config_we, config_addr, config_data,
    input  config_ready, read_data, read_valid
  );

  modport slave (
    input  config_valid, config_we, config_addr, config_data,
    output config_ready, read_data, read_valid
  );

endinterface

// File: rtl/pe_tile_config_regs_decode.sv
// cfg_addr_decode: combinational decode of a configuration address.
// Ports: tile_id/addr/we in; match_c, reg_idx_c and one-hot-ish command
// class flags out. All class flags are already qualified by the tile match,
// and illegal_c covers any matching access that is not a legal operation.
module cfg_addr_decode
  import pe_tile_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [15:0]       tile_id,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              match_c,
  output logic [IDX_W-1:0]  reg_idx_c,
  output logic              is_reg_c,
  output logic              is_commit_c,
  output logic              is_abort_c,
  output logic              is_status_c,
  output logic              illegal_c
);

  logic [REGID_W-1:0] reg_id;

  always_comb begin
    reg_id      = addr[REGID_W-1:0];
    match_c     = (addr[ADDR_W-1:REGID_W] == tile_id);
    reg_idx_c   = IDX_W'(reg_id);
    is_reg_c    = match_c && (reg_id < REGID_W'(NUM_REGS));
    // commit/abort are write-only commands, status is read-only
    is_commit_c = match_c && we  && (reg_id == REG_ID_COMMIT);
    is_abort_c  = match_c && we  && (reg_id == REG_ID_ABORT);
    is_status_c = match_c && !we && (reg_id == REG_ID_STATUS);
    illegal_c   = match_c && !(is_reg_c || is_commit_c || is_abort_c || is_status_c);
  end

endmodule

// File: rtl/pe_tile_config_regs.sv
// pe_tile_config_regs: configuration register bank for one PE tile.
// Writes land in shadow registers and set a dirty bit; a commit command walks
// the bank one register per cycle copying dirty shadows into the active
// registers that drive the tile.
// Ports: clk, reset (async active-low), tile_id, cfg (command bus slave),
// cfg_out (active regs, reg i at [i*REG_WIDTH +: REG_WIDTH]), config_en
// (per-reg update pulse), busy (commit walk in progress), cfg_err (sticky).
module pe_tile_config_regs
  import pe_tile_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned TILE_ID_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TILE_ID_W-1:0]          tile_id,
  pe_tile_config_regs_if.slave          cfg,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_out,
  output logic [NUM_REGS-1:0]           config_en,
  output logic                          busy,
  output logic                          cfg_err
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [NUM_REGS-1:0][REG_WIDTH-1:0] reg_bank_t;

  cfg_state_e         state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  reg_bank_t          shadow_q, shadow_d;
  reg_bank_t          active_q, active_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               match_c, is_reg_c, is_commit_c, is_abort_c, is_status_c, illegal_c;
  logic [IDX_W-1:0]   reg_idx_c;
  logic               accept_c;

  cfg_addr_decode #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_decode (
    .tile_id     (tile_id),
    .addr        (cfg.config_addr),
    .we          (cfg.config_we),
    .match_c     (match_c),
    .reg_idx_c   (reg_idx_c),
    .is_reg_c    (is_reg_c),
    .is_commit_c (is_commit_c),
    .is_abort_c  (is_abort_c),
    .is_status_c (is_status_c),
    .illegal_c   (illegal_c)
  );

  assign accept_c = cfg.config_valid && ready_q;

  // Next-state: command handling in IDLE, one-register-per-cycle walk in COMMIT
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    en_d     = '0;
    err_d    = err_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c && match_c) begin
          if (is_reg_c) begin
            if (cfg.config_we) begin
              shadow_d[reg_idx_c] = cfg.config_data[REG_WIDTH-1:0];
              dirty_d[reg_idx_c]  = 1'b1;
            end else begin
              rvalid_d = 1'b1;
              rdata_d  = DATA_W'(active_q[reg_idx_c]);
            end
          end
          if (is_status_c) begin
            rvalid_d = 1'b1;
            rdata_d  = DATA_W'(dirty_q);
          end
          if (is_commit_c) begin
            state_d = ST_COMMIT;
            k_d     = '0;
          end
          if (is_abort_c) begin
            shadow_d = active_q;
            dirty_d  = '0;
          end
          if (illegal_c) begin
            err_d = 1'b1;
            if (!cfg.config_we) begin
              rvalid_d = 1'b1;
              rdata_d  = '0;
            end
          end
        end
      end
      ST_COMMIT: begin
        if (dirty_q[k_q]) begin
          active_d[k_q] = shadow_q[k_q];
          dirty_d[k_q]  = 1'b0;
          en_d[k_q]     = 1'b1;
        end
        if (k_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // handshake/status flags track the state being entered so they stay registered
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= '0;
      en_q     <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      en_q     <= en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg.config_ready = ready_q;
  assign cfg.read_valid   = rvalid_q;
  assign cfg.read_data    = rdata_q;
  assign cfg_out          = active_q;
  assign config_en        = en_q;
  assign busy             = busy_q;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_pe_tile_config_regs.sv
// Testbench for pe_tile_config_regs: directed commands, readback checked by a
// scoreboard queue popped from an independent read_valid monitor.
module tb_pe_tile_config_regs;

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_WIDTH = 32;

  logic                          clk;
  logic                          reset;
  logic [15:0]                   tile_id;
  logic [NUM_REGS*REG_WIDTH-1:0] cfg_out;
  logic [NUM_REGS-1:0]           config_en;
  logic                          busy;
  logic                          cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  pe_tile_config_regs_if cfg_if ();

  pe_tile_config_regs #(
    .NUM_REGS  (NUM_REGS),
    .REG_WIDTH (REG_WIDTH),
    .TILE_ID_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tile_id   (tile_id),
    .cfg       (cfg_if.slave),
    .cfg_out   (cfg_out),
    .config_en (config_en),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Readback monitor: every read_valid must match the oldest expected value
  always @(negedge clk) begin
    if (reset && cfg_if.read_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_unexpected: got %0h expected no read_valid", cfg_if.read_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cfg_if.read_data !== e) begin
          n_fail++;
          $display("FAIL read_data: got %0h expected %0h", cfg_if.read_data, e);
        end
      end
    end
  end

  // Present a command from a negedge and hold it until accepted
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    cfg_if.config_valid = 1'b1;
    cfg_if.config_we    = we;
    cfg_if.config_addr  = addr;
    cfg_if.config_data  = data;
    while (!cfg_if.config_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 100 cycles");
      cfg_if.config_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cfg_if.config_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(1'b0, addr, 32'h0);
  endtask

  // Commit and check busy/ready/config_en cycle by cycle (cycles t+1..t+5)
  task automatic do_commit(input string name, input logic [19:0] exp_en);
    logic [19:0] en_seq;
    int          busy_cnt;
    logic        ready_mid;
    en_seq    = '0;
    busy_cnt  = 0;
    ready_mid = 1'b0;
    issue(1'b1, 32'h0001_FFFF, 32'h0);
    for (int i = 1; i <= NUM_REGS + 1; i++) begin
      @(negedge clk);
      en_seq = {en_seq[15:0], config_en};
      if (busy) busy_cnt++;
      if (i <= NUM_REGS && cfg_if.config_ready) ready_mid = 1'b1;
    end
    check({name, "_en_seq"}, 128'(en_seq), 128'(exp_en));
    check({name, "_busy_cycles"}, 128'(busy_cnt), 128'(NUM_REGS));
    check({name, "_ready_low"}, 128'(ready_mid), 128'(1'b0));
    check({name, "_ready_back"}, 128'(cfg_if.config_ready), 128'(1'b1));
  endtask

  initial begin
    cfg_if.config_valid = 1'b0;
    cfg_if.config_we    = 1'b0;
    cfg_if.config_addr  = 32'h0;
    cfg_if.config_data  = 32'h0;
    tile_id             = 16'h0001;
    reset               = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ready", 128'(cfg_if.config_ready), 128'(1'b1));
    check("rst_rvalid", 128'(cfg_if.read_valid), 128'(1'b0));
    check("rst_rdata", 128'(cfg_if.read_data), 128'(0));
    check("rst_cfg_out", 128'(cfg_out), 128'(0));
    check("rst_en", 128'(config_en), 128'(0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_err", 128'(cfg_err), 128'(1'b0));
    reset = 1'b1;

    // shadow write sets dirty bit 2, active untouched
    issue(1'b1, 32'h0001_0002, 32'hDEAD_BEEF);
    rd(32'h0001_FFFD, 32'h0000_0004);
    rd(32'h0001_0002, 32'h0000_0000);
    @(negedge clk);
    check("shadow_no_glitch", 128'(cfg_out), 128'(0));

    // abort drops the pending write; empty commit still walks 4 cycles
    issue(1'b1, 32'h0001_FFFE, 32'h0);
    rd(32'h0001_FFFD, 32'h0000_0000);
    do_commit("empty_commit", 20'h00000);
    check("empty_commit_cfg_out", 128'(cfg_out), 128'(0));

    // write regs 0 and 3, commit: pulses 0001, idle, idle, 1000
    issue(1'b1, 32'h0001_0000, 32'h1111_1111);
    issue(1'b1, 32'h0001_0003, 32'h3333_3333);
    rd(32'h0001_FFFD, 32'h0000_0009);
    do_commit("commit_0_3", 20'h01008);
    check("commit_cfg_out", 128'(cfg_out), 128'({32'h3333_3333, 32'h0, 32'h0, 32'h1111_1111}));
    rd(32'h0001_0000, 32'h1111_1111);
    rd(32'h0001_0003, 32'h3333_3333);
    rd(32'h0001_0002, 32'h0000_0000);
    rd(32'h0001_FFFD, 32'h0000_0000);

    // write reg 1 then abort: no pulses on the following commit
    issue(1'b1, 32'h0001_0001, 32'hAAAA_5555);
    rd(32'h0001_FFFD, 32'h0000_0002);
    issue(1'b1, 32'h0001_FFFE, 32'h0);
    rd(32'h0001_FFFD, 32'h0000_0000);
    do_commit("abort_commit", 20'h00000);
    check("abort_cfg_out", 128'(cfg_out), 128'({32'h3333_3333, 32'h0, 32'h0, 32'h1111_1111}));

    // other tile: accepted, ignored, no error, no readback
    issue(1'b1, 32'h0002_0001, 32'h1234_5678);
    issue(1'b0, 32'h0002_0000, 32'h0);
    repeat (2) @(negedge clk);
    check("foreign_no_err", 128'(cfg_err), 128'(1'b0));
    rd(32'h0001_FFFD, 32'h0000_0000);

    // out-of-range reg id: sticky error, illegal read returns 0
    issue(1'b1, 32'h0001_0007, 32'hFFFF_FFFF);
    @(negedge clk);
    check("illegal_wr_err", 128'(cfg_err), 128'(1'b1));
    rd(32'h0001_0009, 32'h0000_0000);
    rd(32'h0001_FFFF, 32'h0000_0000);
    rd(32'h0001_FFFD, 32'h0000_0000);

    // reset during cycle 2 of a commit: everything clears immediately
    issue(1'b1, 32'h0001_0000, 32'h0000_005A);
    issue(1'b1, 32'h0001_0002, 32'h0000_00A5);
    issue(1'b1, 32'h0001_FFFF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_commit_en0", 128'(config_en), 128'(4'b0001));
    reset = 1'b0;
    #1;
    check("mid_rst_cfg_out", 128'(cfg_out), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(1'b0));
    check("mid_rst_ready", 128'(cfg_if.config_ready), 128'(1'b1));
    check("mid_rst_en", 128'(config_en), 128'(0));
    check("mid_rst_err", 128'(cfg_err), 128'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 128'({busy, cfg_if.config_ready}), 128'(2'b01));
    check("post_rst_cfg_out", 128'(cfg_out), 128'(0));
    rd(32'h0001_FFFD, 32'h0000_0000);
    rd(32'h0001_0000, 32'h0000_0000);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
